// File: rtl/axi_master_pkg.sv
// Shared AXI4 master definitions: state encoding, protocol codes and size helper.
// Used by both the burst write master and the burst read master.
package axi_master_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WA_WAIT  = 3'd1;
  localparam logic [2:0] ST_WA_START = 3'd2;
  localparam logic [2:0] ST_AW_HS    = 3'd3;
  localparam logic [2:0] ST_WD_PROC  = 3'd4;
  localparam logic [2:0] ST_WB_WAIT  = 3'd5;
  localparam logic [2:0] ST_WR_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WA_WAIT   = ST_WA_WAIT,
    WA_START  = ST_WA_START,
    AW_HS     = ST_AW_HS,
    WD_PROC   = ST_WD_PROC,
    WB_WAIT   = ST_WB_WAIT,
    WR_DONE_S = ST_WR_DONE
  } wr_state_e;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;

  // AxSIZE encoding: log2 of bytes per beat.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Burst beat counter: counts accepted beats and flags the final one (cnt == len_m1).
module axi_beat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] len_m1,
  output logic [7:0] cnt,
  output logic       last_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign last_c = (cnt == len_m1);

endmodule

// File: rtl/axi_master_write.sv
// AXI4 INCR burst write master draining an FWFT FIFO (1..MAX_BEATS beats per command).
// Optional BRESP error flag enabled by defining AXI_MASTER_WRITE_BRESP_CHECK_EN.
module axi_master_write
  import axi_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_BEATS  = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESET,

  output logic                      M_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                M_AXI_AWLEN,
  output logic [2:0]                M_AXI_AWSIZE,
  output logic [1:0]                M_AXI_AWBURST,
  output logic [1:0]                M_AXI_AWLOCK,
  output logic [3:0]                M_AXI_AWCACHE,
  output logic [2:0]                M_AXI_AWPROT,
  output logic [3:0]                M_AXI_AWQOS,
  output logic                      M_AXI_AWUSER,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,

  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WLAST,
  output logic                      M_AXI_WUSER,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,

  input  logic                      M_AXI_BID,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BUSER,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,

  input  logic                      WR_START,
  input  logic [ADDR_WIDTH-1:0]     WR_ADRS,
  input  logic [31:0]               WR_LEN,
  output logic                      WR_READY,

  output logic                      WR_FIFO_RE,
  input  logic [DATA_WIDTH-1:0]     WR_FIFO_DATA,
  input  logic                      WR_FIFO_EMPTY,

  output logic                      WR_DONE,
  output logic                      WR_ERR
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  wr_state_e             state;
  logic [ADDR_WIDTH-1:0] adrs_q;
  logic [7:0]            len_m1_q;
  logic                  awvalid_q;

  logic                  start_ok_c;
  logic [31:0]           len_clamp_c;
  logic                  w_hs_c;
  logic                  cnt_last_c;
  logic [7:0]            beat_cnt;

  assign start_ok_c  = (state == IDLE) && WR_START && (WR_LEN != 32'd0);
  assign len_clamp_c = (WR_LEN > 32'(MAX_BEATS)) ? 32'(MAX_BEATS) : WR_LEN;

  // Data beats follow FIFO occupancy directly; FWFT keeps WDATA stable while stalled.
  assign M_AXI_WVALID = (state == WD_PROC) && !WR_FIFO_EMPTY;
  assign w_hs_c       = M_AXI_WVALID && M_AXI_WREADY;
  assign M_AXI_WLAST  = M_AXI_WVALID && cnt_last_c;
  assign WR_FIFO_RE   = w_hs_c;

  assign M_AXI_BREADY = (state == WB_WAIT);
  assign WR_READY     = (state == IDLE);
  assign WR_DONE      = (state == WR_DONE_S);

  assign M_AXI_AWID    = 1'b0;
  assign M_AXI_AWADDR  = adrs_q;
  assign M_AXI_AWLEN   = len_m1_q;
  assign M_AXI_AWSIZE  = axi_size(DATA_WIDTH);
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 2'b00;
  assign M_AXI_AWCACHE = CACHE_BUF_MOD;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = 1'b1;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = WR_FIFO_DATA;
  assign M_AXI_WSTRB   = {STRB_WIDTH{1'b1}};
  assign M_AXI_WUSER   = 1'b0;

  // Command sequencer: AW handshake, then W beats, then B response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      adrs_q    <= '0;
      len_m1_q  <= 8'd0;
      awvalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok_c) begin
            adrs_q   <= WR_ADRS;
            len_m1_q <= 8'(len_clamp_c - 32'd1);
            state    <= WA_WAIT;
          end
        end
        WA_WAIT: state <= WA_START;
        WA_START: begin
          awvalid_q <= 1'b1;
          state     <= AW_HS;
        end
        AW_HS: begin
          if (awvalid_q && M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            state     <= WD_PROC;
          end
        end
        WD_PROC: begin
          if (w_hs_c && cnt_last_c) state <= WB_WAIT;
        end
        WB_WAIT: begin
          if (M_AXI_BVALID) state <= WR_DONE_S;
        end
        WR_DONE_S: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  axi_beat_counter u_beat_counter (
    .clk    (ACLK),
    .rst    (ARESET),
    .en     (w_hs_c),
    .clr    (w_hs_c && cnt_last_c),
    .len_m1 (len_m1_q),
    .cnt    (beat_cnt),
    .last_c (cnt_last_c)
  );

`ifdef AXI_MASTER_WRITE_BRESP_CHECK_EN
  logic err_q;
  logic unused_ok;

  // Sticky until the next accepted command so the caller can read it with WR_DONE.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_q <= 1'b0;
    end else if (start_ok_c) begin
      err_q <= 1'b0;
    end else if ((state == WB_WAIT) && M_AXI_BVALID && (M_AXI_BRESP != RESP_OKAY)) begin
      err_q <= 1'b1;
    end
  end

  assign WR_ERR    = err_q;
  assign unused_ok = ^{M_AXI_BID, M_AXI_BUSER, beat_cnt};
`else
  logic unused_ok;

  assign WR_ERR    = 1'b0;
  assign unused_ok = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_BRESP, beat_cnt};
`endif

endmodule
